// File: rtl/rv32i_types.sv
// Shared types and constants for the cacheline adapter.
//
// Contents:
//   LINE_W_DEFAULT / BEAT_W_DEFAULT : default cacheline and burst beat widths
//   NUM_BEATS / COUNT_W             : beats per line and width of the beat counter
//   OFFSET_W                        : byte-offset bits cleared on the memory address
//   adapter_state_e                 : adapter FSM state encoding
package rv32i_types;

  localparam int unsigned LINE_W_DEFAULT = 256;
  localparam int unsigned BEAT_W_DEFAULT = 64;
  localparam int unsigned NUM_BEATS      = 4;
  localparam int unsigned COUNT_W        = 2;
  localparam int unsigned OFFSET_W       = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adapter_state_e;

endpackage

// File: rtl/adapter_control.sv
// Control FSM for the cacheline adapter.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   read_i        : line read request from the arbiter (wins over write_i)
//   write_i       : line write request from the arbiter
//   resp_i        : per-beat valid/accept from memory
//   last_beat_i   : beat counter is on the final beat of the line
//   state_o       : current FSM state (debug / checker visibility)
//   start_o       : leaving IDLE this cycle; datapath latches address and line
//   accept_o      : a beat is transferred this cycle
//   resp_o        : line completion pulse to the arbiter
//   read_o        : burst read request to memory
//   write_o       : burst write request to memory
//
// Handshake: a beat moves on every cycle where the adapter is in READ or
// WRITE and memory raises resp_i; resp_i=0 stalls for any number of cycles,
// and resp_i outside READ/WRITE is ignored.
//
// Build option ADAPTER_FAST_RESP_EN: when defined, DONE is never entered and
// resp_o is raised in the cycle the final beat is accepted.
module adapter_control
  import rv32i_types::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           read_i,
  input  logic           write_i,
  input  logic           resp_i,
  input  logic           last_beat_i,
  output adapter_state_e state_o,
  output logic           start_o,
  output logic           accept_o,
  output logic           resp_o,
  output logic           read_o,
  output logic           write_o
);

  adapter_state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_o  = 1'b0;
    accept_o = 1'b0;
    resp_o   = 1'b0;
    read_o   = 1'b0;
    write_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_i) begin
          state_d = READ;
          start_o = 1'b1;
        end else if (write_i) begin
          state_d = WRITE;
          start_o = 1'b1;
        end
      end
      READ, WRITE: begin
        read_o  = (state_q == READ);
        write_o = (state_q == WRITE);
        if (resp_i) begin
          accept_o = 1'b1;
          if (last_beat_i) begin
`ifdef ADAPTER_FAST_RESP_EN
            state_d = IDLE;
            resp_o  = 1'b1;
`else
            state_d = DONE;
`endif
          end
        end
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/cacheline_adapter.sv
// Cacheline adapter: converts one LINE_W-bit line request from the arbiter
// into a 4-beat BEAT_W-bit burst to memory, and back.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   address_i           : line address from the arbiter
//   line_i              : write line from the arbiter
//   read_i / write_i    : line request, held by the arbiter until resp_o
//   line_o              : assembled read line (holds the last completed read)
//   resp_o              : one-cycle line completion pulse
//   address_o           : line-aligned burst address to memory
//   burst_o / burst_i   : write beat out / read beat in (beat 0 = line bits [BEAT_W-1:0])
//   read_o / write_o    : burst request to memory
//   resp_i              : per-beat valid/accept from memory
//
// Build option ADAPTER_FAST_RESP_EN: completion is reported in the cycle the
// last beat is accepted, with the top beat of a read taken straight from
// burst_i that cycle. Default build adds one DONE cycle after the last beat.
module cacheline_adapter
  import rv32i_types::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEFAULT,
  parameter int unsigned BEAT_W = BEAT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic [31:0]       address_o,
  output logic [BEAT_W-1:0] burst_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  adapter_state_e      state;
  logic                start;
  logic                accept;
  logic                last_beat;

  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   rd_line_q;
  logic [31:0]         addr_q;
  logic [COUNT_W-1:0]  count_q;
  logic [LINE_W-1:0]   rd_line_final;
  logic                unused_addr_bits;

  assign last_beat = (count_q == COUNT_W'(NUM_BEATS - 1));

  adapter_control u_control (
    .clk         (clk),
    .rst         (rst),
    .read_i      (read_i),
    .write_i     (write_i),
    .resp_i      (resp_i),
    .last_beat_i (last_beat),
    .state_o     (state),
    .start_o     (start),
    .accept_o    (accept),
    .resp_o      (resp_o),
    .read_o      (read_o),
    .write_o     (write_o)
  );

  // Buffer contents once the beat on burst_i is merged in; on the final read
  // beat this is the completed line.
  always_comb begin
    rd_line_final = line_q;
    rd_line_final[count_q*BEAT_W +: BEAT_W] = burst_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q    <= '0;
      rd_line_q <= '0;
      addr_q    <= '0;
      count_q   <= '0;
    end else begin
      if (start) begin
        addr_q <= address_i;
        line_q <= line_i;
      end
      if (accept) begin
        // Count wraps to 0 after the last beat, ready for the next line.
        count_q <= count_q + 1'b1;
        if (state == READ) begin
          line_q <= rd_line_final;
          if (last_beat) begin
            rd_line_q <= rd_line_final;
          end
        end
      end
    end
  end

  assign address_o = {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
  assign unused_addr_bits = ^addr_q[OFFSET_W-1:0];

  assign burst_o = (state == WRITE) ? line_q[count_q*BEAT_W +: BEAT_W] : '0;

`ifdef ADAPTER_FAST_RESP_EN
  assign line_o = (state == READ && accept && last_beat) ? rd_line_final : rd_line_q;
`else
  assign line_o = (state == DONE) ? line_q : rd_line_q;
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed testbench for cacheline_adapter: read, write, stalled read,
// simultaneous request, mid-burst reset, back-to-back reads, resp_i in IDLE.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_compared = 0;
  int n_failed   = 0;

  cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .line_i    (line_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one read line request; memory answers according to pat[0..npat-1]
  // (1 = beat presented with resp_i, 0 = stall with junk on burst_i).
  task automatic read_txn(input string tag, input logic [31:0] addr, input logic [255:0] exp_line,
                          input logic [7:0] pat, input int npat, input bit with_write, input bit keep_req);
    int b;
    b         = 0;
    address_i = addr;
    read_i    = 1'b1;
    write_i   = with_write;
    resp_i    = 1'b0;
    step();
    for (int i = 0; i < npat; i++) begin
      check({tag, ".read_o"}, 256'(read_o), 256'(1'b1));
      check({tag, ".write_o"}, 256'(write_o), 256'(1'b0));
      check({tag, ".address_o"}, 256'(address_o), 256'(addr & 32'hFFFF_FFE0));
      resp_i = pat[i];
      if (pat[i]) begin
        burst_i = exp_line[b*64 +: 64];
        b++;
      end else begin
        burst_i = {$urandom, $urandom};
      end
      #1;
`ifdef ADAPTER_FAST_RESP_EN
      check({tag, ".resp_o"}, 256'(resp_o), 256'(i == npat - 1));
      if (i == npat - 1) check({tag, ".line_o_fast"}, line_o, exp_line);
`else
      check({tag, ".resp_o"}, 256'(resp_o), 256'(1'b0));
`endif
      step();
    end
    resp_i = 1'b0;
`ifndef ADAPTER_FAST_RESP_EN
    check({tag, ".done_resp_o"}, 256'(resp_o), 256'(1'b1));
    check({tag, ".done_line_o"}, line_o, exp_line);
    check({tag, ".done_read_o"}, 256'(read_o), 256'(1'b0));
    if (!keep_req) begin
      read_i  = 1'b0;
      write_i = 1'b0;
    end
    step();
`else
    if (!keep_req) begin
      read_i  = 1'b0;
      write_i = 1'b0;
    end
`endif
    // IDLE cycle: pulse over, line held, no request to memory even if read_i held
    check({tag, ".idle_resp_o"}, 256'(resp_o), 256'(1'b0));
    check({tag, ".idle_line_o"}, line_o, exp_line);
    check({tag, ".idle_read_o"}, 256'(read_o), 256'(1'b0));
  endtask

  task automatic write_txn(input string tag, input logic [31:0] addr, input logic [255:0] line,
                           input logic [255:0] held_line);
    address_i = addr;
    line_i    = line;
    write_i   = 1'b1;
    read_i    = 1'b0;
    resp_i    = 1'b0;
    step();
    line_i = '0;
    for (int i = 0; i < 4; i++) begin
      check({tag, ".write_o"}, 256'(write_o), 256'(1'b1));
      check({tag, ".read_o"}, 256'(read_o), 256'(1'b0));
      check({tag, ".burst_o"}, 256'(burst_o), 256'(line[i*64 +: 64]));
      check({tag, ".address_o"}, 256'(address_o), 256'(addr & 32'hFFFF_FFE0));
      resp_i = 1'b1;
      #1;
`ifdef ADAPTER_FAST_RESP_EN
      check({tag, ".resp_o"}, 256'(resp_o), 256'(i == 3));
`else
      check({tag, ".resp_o"}, 256'(resp_o), 256'(1'b0));
`endif
      step();
    end
    resp_i = 1'b0;
`ifndef ADAPTER_FAST_RESP_EN
    check({tag, ".done_resp_o"}, 256'(resp_o), 256'(1'b1));
    check({tag, ".done_write_o"}, 256'(write_o), 256'(1'b0));
    write_i = 1'b0;
    step();
`else
    write_i = 1'b0;
`endif
    check({tag, ".idle_resp_o"}, 256'(resp_o), 256'(1'b0));
    check({tag, ".idle_write_o"}, 256'(write_o), 256'(1'b0));
    check({tag, ".idle_line_o"}, line_o, held_line);
  endtask

  // ---------------- stimulus ----------------
  logic [255:0] rd_line1, rd_line2, rd_line3, rd_line4, rd_line5, wr_line;

  initial begin
    rd_line1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    rd_line2 = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    rd_line3 = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303, 64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    rd_line4 = {64'hFEED_FACE_0000_0004, 64'hFEED_FACE_0000_0003, 64'hFEED_FACE_0000_0002, 64'hFEED_FACE_0000_0001};
    rd_line5 = {64'h5555_AAAA_5555_AAAA, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_F0F0_F0F0, 64'hCAFE_BABE_DEAD_BEEF};
    wr_line  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0};

    rst       = 1'b1;
    address_i = '0;
    line_i    = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    repeat (3) step();

    // Reset values
    check("rst.resp_o", 256'(resp_o), 256'(1'b0));
    check("rst.read_o", 256'(read_o), 256'(1'b0));
    check("rst.write_o", 256'(write_o), 256'(1'b0));
    check("rst.address_o", 256'(address_o), 256'(32'h0));
    check("rst.burst_o", 256'(burst_o), 256'(64'h0));
    check("rst.line_o", line_o, 256'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Basic read
    read_txn("rd", 32'h0000_1234, rd_line1, 8'b0000_1111, 4, 1'b0, 1'b0);

    // Write; line_o must keep showing the last read line afterwards
    write_txn("wr", 32'h0000_ABCD, wr_line, rd_line1);

    // Stalled read: resp_i 1,0,0,1,1,0,1
    read_txn("stall", 32'h8000_00FF, rd_line2, 8'b0101_1001, 7, 1'b0, 1'b0);

    // Simultaneous read and write request: read wins
    read_txn("both", 32'h0000_0040, rd_line3, 8'b0000_1111, 4, 1'b1, 1'b0);

    // Reset after two accepted beats of a read
    address_i = 32'h1234_5678;
    read_i    = 1'b1;
    step();
    resp_i  = 1'b1;
    burst_i = 64'hBAD0_BAD0_BAD0_0001;
    step();
    burst_i = 64'hBAD0_BAD0_BAD0_0002;
    step();
    resp_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst.resp_o", 256'(resp_o), 256'(1'b0));
    check("arst.read_o", 256'(read_o), 256'(1'b0));
    check("arst.write_o", 256'(write_o), 256'(1'b0));
    check("arst.address_o", 256'(address_o), 256'(32'h0));
    check("arst.burst_o", 256'(burst_o), 256'(64'h0));
    check("arst.line_o", line_o, 256'h0);
    @(negedge clk);
    rst    = 1'b0;
    read_i = 1'b0;
    step();
    read_txn("post_rst", 32'h0000_2000, rd_line4, 8'b0000_1111, 4, 1'b0, 1'b0);

    // Back-to-back: read_i held through completion restarts after one IDLE cycle
    read_txn("b2b_a", 32'h0000_3000, rd_line1, 8'b0000_1111, 4, 1'b0, 1'b1);
    read_txn("b2b_b", 32'h0000_3020, rd_line5, 8'b0000_1111, 4, 1'b0, 1'b0);

    // resp_i while idle must not start anything
    resp_i  = 1'b1;
    burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) step();
    check("idle_resp.read_o", 256'(read_o), 256'(1'b0));
    check("idle_resp.write_o", 256'(write_o), 256'(1'b0));
    check("idle_resp.resp_o", 256'(resp_o), 256'(1'b0));
    check("idle_resp.address_o", 256'(address_o), 256'(32'h0000_3020));
    check("idle_resp.line_o", line_o, rd_line5);
    resp_i = 1'b0;
    step();

    // A following read still lands its beats in the right slots
    read_txn("final", 32'hFFFF_FFFF, rd_line3, 8'b0011_0101, 6, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cacheline width in bits.
REQ-002 SHALL have parameter BEAT_W, default 64, memory burst beat width in bits; LINE_W/BEAT_W = 4 beats.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port address_i, input, 32, line address from the arbiter.
REQ-006 SHALL have port line_i, input, LINE_W, write line from the arbiter.
REQ-007 SHALL have port read_i / write_i, input, 1 each, line request from the arbiter, held until resp_o.
REQ-008 SHALL have port line_o, output, LINE_W, assembled read line.
REQ-009 SHALL have port resp_o, output, 1, one-cycle line completion pulse to the arbiter.
REQ-010 SHALL have port address_o, output, 32, burst address to memory.
REQ-011 SHALL have port burst_o / burst_i, output / input, BEAT_W each, write beat out, read beat in.
REQ-012 SHALL have port read_o / write_o, output, 1 each, burst request to memory.
REQ-013 SHALL have port resp_i, input, 1, per-beat valid/accept from memory.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-015 IDLE: read_i -> READ; else write_i -> WRITE; read_i and write_i together -> READ (read priority); address_i latched and line_i captured into the line buffer on exit from IDLE.
REQ-016 address_o SHALL be the latched address with bits [4:0] forced to zero; it SHALL be stable for the whole burst.
REQ-017 READ: read_o=1; each cycle with resp_i=1 stores burst_i into buffer beat[count] (beat 0 = bits [63:0]) and increments the 2-bit count.
REQ-018 WRITE: write_o=1, burst_o=buffer beat[count]; each cycle with resp_i=1 advances the count.
REQ-019 Cycles with resp_i=0 in READ/WRITE SHALL hold the count and buffer (stall of any length).
REQ-020 Acceptance of beat 3 (count=3, resp_i=1) SHALL move to DONE, with the count wrapping to 0.
REQ-021 DONE: resp_o=1, line_o = buffer; read_o=write_o=0; next state IDLE unconditionally.
REQ-022 A request still asserted in the IDLE cycle following DONE SHALL start a new transaction; the arbiter deasserts on resp_o, so no spurious restart occurs.
REQ-023 resp_i in IDLE or DONE SHALL be ignored.
REQ-024 line_o SHALL hold the last completed read line outside DONE.

Reset
REQ-025 rst SHALL force IDLE, count=0, buffer=0, latched address=0 immediately, including mid-burst.
REQ-026 Reset values: resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, line_o=0.

Configuration
REQ-027 ADAPTER_FAST_RESP_EN defined: DONE state removed; resp_o=1 in the beat-3 acceptance cycle, with line_o[255:192] driven from burst_i that cycle for reads; transaction latency = 4 accepted beats.
REQ-028 ADAPTER_FAST_RESP_EN undefined: DONE state present per REQ-021; latency = 4 accepted beats + 1 cycle.

Structure
REQ-029 The state enum, LINE_W/BEAT_W defaults and the beat count constant (4) SHALL live in rv32i_types.
REQ-030 The FSM SHALL be a sub-module adapter_control; the buffer, count and address register SHALL stay in cacheline_adapter.

Verification
REQ-031 Read: address_i=0x0000_1234, read_i=1, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> address_o=0x0000_1220, line_o={44..,33..,22..,11..}, resp_o one cycle after the 4th beat (same cycle with macro).
REQ-032 Write: line_i=256'h0123...CDEF, write_i=1, resp_i=1 for 4 cycles -> burst_o shows bits [63:0], [127:64], [191:128], [255:192] in order; resp_o pulses once.
REQ-033 Stall: read with resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 beats captured in order; resp_o after the 7th cycle.
REQ-034 Simultaneous read_i=1, write_i=1 -> read_o=1, write_o=0.
REQ-035 rst asserted after beat 2 of a read -> all outputs 0 asynchronously; next read_i completes a full, correct 4-beat read.
REQ-036 Back-to-back: read_i held through DONE -> new burst starts after one IDLE cycle; resp_i in IDLE -> no state change.
